// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave returns results.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output start, abort, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, abort, a, b, ci,
    output busy, done, s, co
  );

endinterface

// File: rtl/fa_bit.sv
// Purely combinational 1-bit full adder cell; the only arithmetic in the serial datapath.
module fa_bit (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one bit per RUN cycle, LSB first, through a single full-adder cell.
// Results land in s/co on the RUN->DONE edge and hold until the next completion.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_s;
  logic               r_carry;
  logic               r_co;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_step;
  logic               w_finish;
  logic               w_last;
  logic               w_busy;
  logic               w_done;
  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_res_next;

  fa_bit u_fa_bit (
    .s  (w_sum),
    .co (w_cout),
    .a  (r_op_a[0]),
    .b  (r_op_b[0]),
    .ci (r_carry)
  );

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; abort outranks everything in RUN, start is ignored there.
  // NOTE: default assignment first so no path through the case leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = RUN;
      RUN: begin
        if (bus.abort)   w_next_state = IDLE;
        else if (w_last) w_next_state = DONE;
      end
      DONE:    w_next_state = bus.start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs and datapath controls.
  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: w_accept = bus.start;
      RUN: begin
        w_busy   = 1'b1;
        w_step   = !bus.abort;
        w_finish = !bus.abort && w_last;
      end
      DONE: begin
        w_done   = 1'b1;
        w_accept = bus.start;
      end
      default: ;
    endcase
  end

  // Serial datapath: load on accept, shift one bit per RUN cycle, publish on the last one.
  // NOTE: every datapath register is cleared by reset so a mid-RUN reset leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= bus.a;
      r_op_b  <= bus.b;
      r_carry <= bus.ci;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_op_a  <= r_op_a >> 1;
      r_op_b  <= r_op_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_finish) begin
        r_s  <= w_res_next;
        r_co <= w_cout;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.s    = r_s;
  assign bus.co   = r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl with a result scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           done_cnt = 0;
  exp_t         sb[$];
  logic [W-1:0] last_s   = '0;
  logic         last_co  = 1'b0;

  // Free-running cycle count and done-pulse count, observed at the active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] sum;
    exp_t       e;
    sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.s  = sum[W-1:0];
    e.co = sum[W];
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_s"}, 32'(bus.s), 32'(e.s));
      check({tag, "_co"}, 32'(bus.co), 32'(e.co));
      last_s  = e.s;
      last_co = e.co;
    end
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  // One complete addition from a negedge: checks busy length, done latency, s/co stability, result.
  task automatic exec_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input string tag);
    int c0;
    int busy_n;
    bit stable;
    bus.a     = a;
    bus.b     = b;
    bus.ci    = ci;
    bus.start = 1'b1;
    push_exp(a, b, ci);
    c0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    busy_n = 0;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.s !== last_s || bus.co !== last_co) stable = 1'b0;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_done_latency"}, 32'(cyc - c0), 32'd9);
    check({tag, "_s_stable_in_run"}, 32'(stable), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    sb_pop_check(tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int c0;
    int d0;
    int c_prev;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_s", 32'(bus.s), 32'd0);
    check("rst_co", 32'(bus.co), 32'd0);

    // Start presented on the first edge after reset release.
    rst_n = 1'b1;
    exec_op(8'h5A, 8'h3C, 1'b0, "basic");
    exec_op(8'hFF, 8'h01, 1'b0, "ripple_b");
    exec_op(8'hFF, 8'h00, 1'b1, "ripple_ci");

    // Start re-pulsed in RUN cycle 3 with different operands is ignored.
    c0 = cyc;
    bus.a = 8'h5A; bus.b = 8'h3C; bus.ci = 1'b0; bus.start = 1'b1;
    push_exp(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(20, "ign");
    check("ign_latency", 32'(cyc - c0), 32'd9);
    sb_pop_check("ign");
    repeat (3) @(negedge clk);
    check("ign_one_done", 32'(done_cnt - d0), 32'd1);
    check("ign_idle", 32'(bus.busy), 32'd0);

    // Abort (with start also high) in RUN cycle 4.
    bus.a = 8'h01; bus.b = 8'h01; bus.ci = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_s", 32'(bus.s), 32'(last_s));
    check("abort_co", 32'(bus.co), 32'(last_co));
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);

    // Reset asserted mid-RUN (cycle 5).
    bus.a = 8'h11; bus.b = 8'h22; bus.ci = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_s", 32'(bus.s), 32'd0);
    check("mrst_co", 32'(bus.co), 32'd0);
    last_s  = '0;
    last_co = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mrst_idle", 32'(bus.busy), 32'd0);
    exec_op(8'h80, 8'h80, 1'b0, "post_rst");

    // Start held high: back-to-back completions through DONE->RUN.
    bus.a  = W'($urandom);
    bus.b  = W'($urandom);
    bus.ci = 1'($urandom);
    push_exp(bus.a, bus.b, bus.ci);
    bus.start = 1'b1;
    c_prev = cyc;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      wait_done(12, "b2b");
      check("b2b_period", 32'(cyc - c_prev), 32'd9);
      check("b2b_busy_in_done", 32'(bus.busy), 32'd0);
      sb_pop_check("b2b");
      c_prev = cyc;
      if (i < 999) begin
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        bus.ci = 1'($urandom);
        push_exp(bus.a, bus.b, bus.ci);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_idle_busy", 32'(bus.busy), 32'd0);
    check("b2b_end_idle_done", 32'(bus.done), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
